// File: rtl/text_periph_target.sv
// Text output peripheral bus target: 16-byte register window, character FIFO, valid/ready drain.
// Optional interrupt output enabled by defining TEXT_PERIPH_IRQ_EN.
module text_periph_target #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        i_cpu_clk,
    input  logic        i_rst,
    input  logic        i_bus_clk,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_data,
    output logic [31:0] o_bus_data,
    output logic        o_bus_data_ready,
    output logic [7:0]  o_char,
    output logic        o_char_valid,
    input  logic        i_char_ready,
    output logic        o_irq
);

    // state      | meaning
    // S_IDLE     | waiting for a rising bus strobe that hits the window
    // S_ACK      | perform the captured access, pulse ready
    // S_WAIT_LOW | wait for the strobe to drop before accepting another
    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT_LOW} state_t;

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0]    ID_VAL  = 32'h5445_5854;

    state_t       state;
    logic         bus_clk_q;
    logic         start_mask_q;
    logic         we_q;
    logic [1:0]   idx_q;
    logic [7:0]   wdata_q;

    logic [7:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  count;
    logic         enable;
    logic         irq_en;
    logic         overflow;

    logic         start;
    logic         hit;
    logic         access;
    logic         empty;
    logic         full;
    logic         push_req;
    logic         push_ok;
    logic         push_drop;
    logic         pop;
    logic         ctrl_wr;
    logic         flush;
    logic         ovf_clr;
    logic [7:0]   status_count;
    logic [31:0]  rdata;
    logic         unused_bits;

    assign unused_bits = ^{i_bus_addr[1:0], i_bus_data[31:8]};

    // The mask keeps a strobe that is already high out of reset from counting as a new edge.
    assign start  = i_bus_clk & ~bus_clk_q & ~start_mask_q;
    assign hit    = (i_bus_addr[31:4] == BASE_ADDR[31:4]);
    assign access = (state == S_ACK);

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign o_char_valid = enable & ~empty;
    assign o_char       = mem[rd_ptr];

    assign push_req  = access & we_q & (idx_q == 2'd0);
    assign ctrl_wr   = access & we_q & (idx_q == 2'd2);
    assign flush     = ctrl_wr & wdata_q[1];
    assign ovf_clr   = access & we_q & (idx_q == 2'd1) & wdata_q[2];
    assign pop       = o_char_valid & i_char_ready & ~flush;
    assign push_ok   = push_req & (~full | pop);
    assign push_drop = push_req & ~push_ok;

    assign status_count = 8'(count);

    always_comb begin
        rdata = '0;
        case (idx_q)
            2'd1:    rdata = {16'h0, status_count, 5'h0, overflow, full, empty};
            2'd2:    rdata = {29'h0, irq_en, 1'b0, enable};
            2'd3:    rdata = ID_VAL;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state            <= S_IDLE;
            bus_clk_q        <= 1'b0;
            start_mask_q     <= 1'b1;
            o_bus_data       <= '0;
            o_bus_data_ready <= 1'b0;
            we_q             <= 1'b0;
            idx_q            <= '0;
            wdata_q          <= '0;
        end else begin
            bus_clk_q        <= i_bus_clk;
            start_mask_q     <= 1'b0;
            o_bus_data_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && hit) begin
                        we_q    <= i_bus_we;
                        idx_q   <= i_bus_addr[3:2];
                        wdata_q <= i_bus_data[7:0];
                        state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    o_bus_data_ready <= 1'b1;
                    if (!we_q) o_bus_data <= rdata;
                    state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (!i_bus_clk) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            enable   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            end
            if (ctrl_wr) enable <= wdata_q[0];
            // A drop outranks a clear landing in the same cycle.
            if (push_drop)    overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_cpu_clk) begin
        if (push_ok) mem[wr_ptr] <= wdata_q;
    end

`ifdef TEXT_PERIPH_IRQ_EN
    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            irq_en <= 1'b0;
            o_irq  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= wdata_q[2];
            o_irq <= enable & irq_en & empty;
        end
    end
`else
    assign irq_en = 1'b0;
    assign o_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_text_periph_target.sv
// Randomized bench for text_periph_target against a queue-based behavioural model.
module tb_text_periph_target;

    localparam logic [31:0] BASE  = 32'h0000_FF00;
    localparam int          DEPTH = 16;
`ifdef TEXT_PERIPH_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        i_rst;
    logic        i_bus_clk;
    logic        i_bus_we;
    logic [31:0] i_bus_addr;
    logic [31:0] i_bus_data;
    logic [31:0] o_bus_data;
    logic        o_bus_data_ready;
    logic [7:0]  o_char;
    logic        o_char_valid;
    logic        i_char_ready;
    logic        o_irq;

    text_periph_target #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .i_cpu_clk        (clk),
        .i_rst            (i_rst),
        .i_bus_clk        (i_bus_clk),
        .i_bus_we         (i_bus_we),
        .i_bus_addr       (i_bus_addr),
        .i_bus_data       (i_bus_data),
        .o_bus_data       (o_bus_data),
        .o_bus_data_ready (o_bus_data_ready),
        .o_char           (o_char),
        .o_char_valid     (o_char_valid),
        .i_char_ready     (i_char_ready),
        .o_irq            (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0]  q[$];
    bit          m_en, m_irqen, m_ovf, m_irq, m_ready;
    logic [31:0] m_rdata;
    bit          cur_we;
    logic [1:0]  cur_idx;
    logic [7:0]  cur_d;
    int          rdy_mode;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] idx);
        case (idx)
            2'd1:    return {16'h0, 8'(q.size()), 5'h0, m_ovf, (q.size() == DEPTH), (q.size() == 0)};
            2'd2:    return {29'h0, m_irqen, 1'b0, m_en};
            2'd3:    return 32'h5445_5854;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input bit acc);
        int n;
        bit pop;
        if (i_rst) begin
            q.delete();
            m_en = 0; m_irqen = 0; m_ovf = 0; m_irq = 0; m_ready = 0; m_rdata = '0;
            return;
        end
        m_irq   = m_en && m_irqen && (q.size() == 0);
        n       = q.size();
        pop     = m_en && (n > 0) && i_char_ready;
        m_ready = acc;
        if (acc && !cur_we) m_rdata = m_read(cur_idx);
        if (acc && cur_we && cur_idx == 2'd2 && cur_d[1]) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && cur_we && cur_idx == 2'd0) begin
                if (n < DEPTH || pop) q.push_back(cur_d);
                else m_ovf = 1;
            end
        end
        if (acc && cur_we && cur_idx == 2'd2) begin
            m_en = cur_d[0];
            if (IRQ_ON) m_irqen = cur_d[2];
        end
        if (acc && cur_we && cur_idx == 2'd1 && cur_d[2]) m_ovf = 0;
    endtask

    task automatic check_outputs();
        bit v;
        v = m_en && (q.size() > 0);
        chk("char_valid", {31'h0, o_char_valid}, {31'h0, v});
        if (v) chk("char", {24'h0, o_char}, {24'h0, q[0]});
        chk("bus_ready", {31'h0, o_bus_data_ready}, {31'h0, m_ready});
        chk("bus_data", o_bus_data, m_rdata);
        chk("irq", {31'h0, o_irq}, {31'h0, m_irq});
    endtask

    task automatic step(input bit acc);
        case (rdy_mode)
            0:       i_char_ready = 1'b0;
            1:       i_char_ready = 1'b1;
            default: i_char_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        model_edge(acc);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic bus(input bit we, input logic [31:0] addr, input logic [31:0] data);
        bit hit;
        hit        = (addr[31:4] == BASE[31:4]);
        i_bus_we   = we;
        i_bus_addr = addr;
        i_bus_data = data;
        i_bus_clk  = 1'b1;
        cur_we     = we;
        cur_idx    = addr[3:2];
        cur_d      = data[7:0];
        step(0);
        step(hit);
        last_rd = o_bus_data;
        step(0);
        i_bus_clk = 1'b0;
        step(0);
        step(0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  idx;
        i_rst = 1'b1; i_bus_clk = 0; i_bus_we = 0; i_bus_addr = 0; i_bus_data = 0;
        i_char_ready = 0; rdy_mode = 0;
        cur_we = 0; cur_idx = 0; cur_d = 0; last_rd = 0;
        @(negedge clk);
        step(0);
        step(0);
        i_rst = 1'b0;
        step(0);

        bus(0, BASE + 32'hC, 32'h0);
        chk("id_read", last_rd, 32'h5445_5854);
        bus(0, BASE + 32'h4, 32'h0);
        chk("status_reset", last_rd, 32'h0000_0001);

        rdy_mode = 1;
        bus(1, BASE + 32'h8, 32'h1);
        bus(1, BASE + 32'h0, 32'h41);
        bus(0, BASE + 32'h4, 32'h0);
        chk("status_after_drain", last_rd, 32'h0000_0001);

        rdy_mode = 0;
        for (int i = 0; i < 17; i++) bus(1, BASE, 32'(i));
        bus(0, BASE + 32'h4, 32'h0);
        chk("status_full_ovf", last_rd, 32'h0000_1006);
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) step(0);
        bus(0, BASE + 32'h4, 32'h0);
        chk("status_drained_ovf", last_rd, 32'h0000_0005);

        rdy_mode = 0;
        for (int i = 0; i < 5; i++) bus(1, BASE, 32'h60 + 32'(i));
        bus(1, BASE + 32'h4, 32'h4);
        bus(1, BASE + 32'h8, 32'h3);
        bus(0, BASE + 32'h4, 32'h0);
        chk("status_flushed", last_rd, 32'h0000_0001);
        bus(0, BASE + 32'h8, 32'h0);
        chk("ctrl_read", last_rd, 32'h0000_0001);

        bus(1, BASE + 32'h10, 32'h55);
        bus(0, 32'h0000_0000, 32'h0);
        bus(0, BASE + 32'h4, 32'h0);
        chk("status_after_miss", last_rd, 32'h0000_0001);

        bus(1, BASE + 32'h8, 32'h5);
        chk("irq_empty", {31'h0, o_irq}, {31'h0, IRQ_ON});
        bus(1, BASE, 32'h7A);
        chk("irq_queued", {31'h0, o_irq}, 32'h0);
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) step(0);
        chk("irq_drained", {31'h0, o_irq}, {31'h0, IRQ_ON});

        // reset while a read is in flight, strobe left high across reset
        i_bus_we = 0; i_bus_addr = BASE + 32'hC; i_bus_clk = 1'b1;
        cur_we = 0; cur_idx = 2'd3;
        step(0);
        i_rst = 1'b1;
        step(0);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) step(0);
        i_bus_clk = 1'b0;
        step(0);
        step(0);

        bus(1, BASE + 32'h8, 32'h1);
        for (int n = 0; n < 300; n++) begin
            rdy_mode = 2;
            idx = 2'($urandom_range(0, 3));
            d   = $urandom;
            if (idx == 2'd2) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 3) == 0) rdy_mode = 0;
            if ($urandom_range(0, 19) == 0)
                bus(1'($urandom_range(0, 1)), BASE + 32'h10 + {26'h0, idx, 4'h0}, d);
            else
                bus((idx == 2'd0) ? 1'b1 : 1'($urandom_range(0, 1)), BASE + {28'h0, idx, 2'b00}, d);
            for (int k = $urandom_range(0, 3); k > 0; k--) step(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
